// File: rtl/fifo_rd_drain.sv
// Read-side drain for fifo_async: issues reads, absorbs read latency in a 2-entry skid buffer.
// Define FIFO_RD_CNT_EN to add rd_word_cnt, a wrapping count of words accepted downstream.
module fifo_rd_drain #(
   parameter int WIDTH     = 8,
   parameter int BURST_LEN = 8
) (
   input  logic             rd_clk,
   input  logic             rrst,
   input  logic             enable,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   input  logic [WIDTH-1:0] fifo_rd_data,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
`ifdef FIFO_RD_CNT_EN
   output logic [15:0]      rd_word_cnt,
`endif
   output logic             busy
);

   localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [WIDTH-1:0]   head_r;
   logic [WIDTH-1:0]   tail_r;
   logic [WIDTH-1:0]   head_nxt_s;
   logic [WIDTH-1:0]   tail_nxt_s;
   logic [1:0]         occ_r;
   logic [1:0]         occ_mid_s;
   logic [1:0]         occ_nxt_s;
   logic               inflight_r;
   logic [IDX_W-1:0]   idx_r;
   logic               pop_s;
   logic               rd_en_s;
   logic [2:0]         level_s;

   // Read issue: the projected fill after this cycle's pop must leave room for the new word
   always_comb begin
      pop_s   = (occ_r != 2'd0) & out_ready;
      level_s = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
      rd_en_s = (state_r == ST_RUN) & ~fifo_empty & (level_s < 3'd2);
   end

   // Skid buffer next state: pop shifts tail to head, then the returning word lands behind it
   always_comb begin
      head_nxt_s = head_r;
      tail_nxt_s = tail_r;
      occ_mid_s  = occ_r;
      occ_nxt_s  = occ_r;
      if (pop_s) begin
         head_nxt_s = tail_r;
         occ_mid_s  = occ_r - 2'd1;
      end else begin
         occ_mid_s  = occ_r;
      end
      if (inflight_r) begin
         if (occ_mid_s == 2'd0) begin
            head_nxt_s = fifo_rd_data;
         end else begin
            tail_nxt_s = fifo_rd_data;
         end
         occ_nxt_s = occ_mid_s + 2'd1;
      end else begin
         occ_nxt_s = occ_mid_s;
      end
   end

   // Control FSM next state; DRAIN only retires once nothing is buffered or returning
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (enable) state_nxt_s = ST_RUN;
            else        state_nxt_s = ST_IDLE;
         end
         ST_RUN: begin
            if (!enable) state_nxt_s = ST_DRAIN;
            else         state_nxt_s = ST_RUN;
         end
         ST_DRAIN: begin
            if (enable)                                 state_nxt_s = ST_RUN;
            else if (!inflight_r && (occ_r == 2'd0))    state_nxt_s = ST_IDLE;
            else                                        state_nxt_s = ST_DRAIN;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, buffer and burst index registers; a read in flight at reset is dropped
   always_ff @(posedge rd_clk) begin
      if (rrst) begin
         state_r    <= ST_IDLE;
         head_r     <= {WIDTH{1'b0}};
         tail_r     <= {WIDTH{1'b0}};
         occ_r      <= 2'd0;
         inflight_r <= 1'b0;
         idx_r      <= {IDX_W{1'b0}};
      end else begin
         state_r    <= state_nxt_s;
         head_r     <= head_nxt_s;
         tail_r     <= tail_nxt_s;
         occ_r      <= occ_nxt_s;
         inflight_r <= rd_en_s;
         if (pop_s) begin
            idx_r <= (idx_r == LAST_IDX) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
         end else begin
            idx_r <= idx_r;
         end
      end
   end

`ifdef FIFO_RD_CNT_EN
   logic [15:0] rd_word_cnt_r;

   // Running count of accepted words, wraps naturally at 16 bits
   always_ff @(posedge rd_clk) begin
      if (rrst) begin
         rd_word_cnt_r <= 16'd0;
      end else if (pop_s) begin
         rd_word_cnt_r <= rd_word_cnt_r + 16'd1;
      end else begin
         rd_word_cnt_r <= rd_word_cnt_r;
      end
   end

   assign rd_word_cnt = rd_word_cnt_r;
`endif

   assign fifo_rd_en = rd_en_s;
   assign out_data   = head_r;
   assign out_valid  = (occ_r != 2'd0);
   assign out_last   = (occ_r != 2'd0) & (idx_r == LAST_IDX);
   assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Scoreboard bench for fifo_rd_drain: a queue-based FIFO model feeds the DUT and
// every accepted output word is popped from an expected queue and compared.
module tb_fifo_rd_drain;

   localparam int W  = 8;
   localparam int BL = 8;

   typedef struct {
      logic [W-1:0] data;
      logic         last;
   } exp_t;

   logic         rd_clk = 1'b0;
   logic         rrst = 1'b1;
   logic         enable = 1'b0;
   logic         fifo_empty = 1'b1;
   logic         fifo_rd_en;
   logic [W-1:0] fifo_rd_data = 8'd0;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic         out_last;
   logic         busy;
`ifdef FIFO_RD_CNT_EN
   logic [15:0]  rd_word_cnt;
`endif

   logic [W-1:0] mem[$];
   exp_t         exp_q[$];
   bit           gap = 1'b0;
   int           k = 0;
   int           cyc = 0;
   int           rd_pulses = 0;
   int           pops = 0;
   int           first_rd_cyc = -1;
   int           first_valid_cyc = -1;
   int           last_pop_cyc = -1;
   int           n_checks = 0;
   int           n_fail = 0;

   fifo_rd_drain #(.WIDTH(W), .BURST_LEN(BL)) dut (
      .rd_clk       (rd_clk),
      .rrst         (rrst),
      .enable       (enable),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_last     (out_last),
`ifdef FIFO_RD_CNT_EN
      .rd_word_cnt  (rd_word_cnt),
`endif
      .busy         (busy)
   );

   initial forever #5 rd_clk = ~rd_clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // FIFO model: one-cycle read latency, read strobe must never see an empty FIFO
   always @(posedge rd_clk) begin
      if (fifo_rd_en) begin
         rd_pulses++;
         if (first_rd_cyc < 0) first_rd_cyc = cyc;
         check_eq("rd_en_vs_empty", {31'd0, fifo_empty}, 32'd0);
         if (mem.size() > 0) fifo_rd_data <= mem.pop_front();
      end
      cyc <= cyc + 1;
   end

   // Empty flag follows the model contents, settled just after the stimulus edge
   always @(negedge rd_clk) begin
      #1;
      fifo_empty = (mem.size() == 0) || gap;
   end

   // Output monitor just before the active edge: each handshake pops the scoreboard
   always @(negedge rd_clk) begin
      exp_t e;
      #4;
      if (!rrst && out_valid) begin
         if (first_valid_cyc < 0) first_valid_cyc = cyc;
         if (out_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_pop", {24'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check_eq("pop_data", {24'd0, out_data}, {24'd0, e.data});
               check_eq("pop_last", {31'd0, out_last}, {31'd0, e.last});
            end
            pops++;
            last_pop_cyc = cyc;
         end
      end
   end

   task automatic push_word(input logic [W-1:0] w);
      exp_t e;
      e.data = w;
      e.last = ((k % BL) == (BL - 1));
      k++;
      mem.push_back(w);
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      rrst = 1'b1;
      enable = 1'b0;
      out_ready = 1'b0;
      gap = 1'b0;
      mem.delete();
      exp_q.delete();
      k = 0;
      repeat (2) @(negedge rd_clk);
      check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_out_last", {31'd0, out_last}, 32'd0);
      check_eq("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_out_data", {24'd0, out_data}, 32'd0);
      rrst = 1'b0;
      @(negedge rd_clk);
   endtask

   task automatic wait_pops(input int n, input string tag);
      int base = pops;
      int t = 0;
      while ((pops - base) < n && t < 300) begin
         @(negedge rd_clk);
         t++;
      end
      check_eq(tag, pops - base, n);
   endtask

   task automatic wait_idle(input string tag);
      int t = 0;
      while (busy && t < 100) begin
         @(negedge rd_clk);
         t++;
      end
      check_eq(tag, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int r0;
      int r1;
      int p0;
      int t;
      logic [W-1:0] b2b[8] = '{8'd3, 8'd17, 8'd0, 8'd29, 8'd5, 8'd12, 8'd8, 8'd21};

      do_reset();

      // Back-to-back drain
      foreach (b2b[i]) push_word(b2b[i]);
      r0 = rd_pulses;
      first_rd_cyc = -1;
      first_valid_cyc = -1;
      enable = 1'b1;
      out_ready = 1'b1;
      wait_pops(8, "b2b_pops");
      check_eq("b2b_latency", first_valid_cyc - first_rd_cyc, 2);
      check_eq("b2b_rate", last_pop_cyc - first_valid_cyc, 7);
      check_eq("b2b_rd_pulses", rd_pulses - r0, 8);
      enable = 1'b0;
      wait_idle("b2b_idle");

      // Backpressure
      do_reset();
      for (int i = 0; i < 6; i++) push_word(8'(40 + i * 7));
      r0 = rd_pulses;
      enable = 1'b1;
      repeat (10) @(negedge rd_clk);
      check_eq("bp_rd_pulses", rd_pulses - r0, 2);
      check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_head", {24'd0, out_data}, 32'd40);
      repeat (3) @(negedge rd_clk);
      check_eq("bp_head_stable", {24'd0, out_data}, 32'd40);
      check_eq("bp_rd_pulses_hold", rd_pulses - r0, 2);
      out_ready = 1'b1;
      wait_pops(6, "bp_pops");
      check_eq("bp_rd_total", rd_pulses - r0, 6);
      enable = 1'b0;
      wait_idle("bp_idle");

      // Stop mid-stream, then resume
      do_reset();
      for (int i = 0; i < 8; i++) push_word(8'(100 + i));
      r0 = rd_pulses;
      p0 = pops;
      enable = 1'b1;
      out_ready = 1'b1;
      wait_pops(3, "stop_first3");
      enable = 1'b0;
      @(negedge rd_clk);
      r1 = rd_pulses;
      check_eq("stop_state_drain", {30'd0, dut.state_r}, 32'd2);
      wait_idle("stop_idle");
      check_eq("stop_no_rd_in_drain", rd_pulses, r1);
      check_eq("stop_delivered", pops - p0, rd_pulses - r0);
      check_eq("stop_no_loss", exp_q.size(), mem.size());
      enable = 1'b1;
      wait_pops(8 - (pops - p0), "stop_resume_pops");
      enable = 1'b0;
      wait_idle("stop_idle2");

      // FIFO empty toggling every two cycles
      do_reset();
      for (int i = 0; i < 12; i++) push_word(8'(200 + i));
      enable = 1'b1;
      out_ready = 1'b1;
      t = 0;
      while (exp_q.size() > 0 && t < 200) begin
         gap = ((t / 2) % 2) == 1;
         @(negedge rd_clk);
         t++;
      end
      gap = 1'b0;
      check_eq("gap_all_delivered", exp_q.size(), 0);
      enable = 1'b0;
      wait_idle("gap_idle");

      // Reset with words buffered and one in flight
      do_reset();
      for (int i = 0; i < 5; i++) push_word(8'(60 + i));
      r0 = rd_pulses;
      enable = 1'b1;
      t = 0;
      while ((rd_pulses - r0) < 2 && t < 50) begin
         @(negedge rd_clk);
         t++;
      end
      check_eq("mid_rst_setup", rd_pulses - r0, 2);
      rrst = 1'b1;
      mem.delete();
      exp_q.delete();
      k = 0;
      @(negedge rd_clk);
      check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check_eq("mid_rst_last", {31'd0, out_last}, 32'd0);
      check_eq("mid_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
      rrst = 1'b0;
      for (int i = 0; i < 8; i++) push_word(8'(80 + i));
      out_ready = 1'b1;
      wait_pops(8, "mid_rst_pops");
      enable = 1'b0;
      wait_idle("mid_rst_idle");

`ifdef FIFO_RD_CNT_EN
      // Word counter wrap
      do_reset();
      check_eq("cnt_reset", {16'd0, rd_word_cnt}, 32'd0);
      for (int i = 0; i < 3; i++) push_word(8'(150 + i));
      enable = 1'b1;
      repeat (6) @(negedge rd_clk);
      force dut.rd_word_cnt_r = 16'd65534;
      #1;
      release dut.rd_word_cnt_r;
      out_ready = 1'b1;
      @(negedge rd_clk);
      check_eq("cnt_65535", {16'd0, rd_word_cnt}, 32'd65535);
      @(negedge rd_clk);
      check_eq("cnt_wrap0", {16'd0, rd_word_cnt}, 32'd0);
      @(negedge rd_clk);
      check_eq("cnt_1", {16'd0, rd_word_cnt}, 32'd1);
      do_reset();
      check_eq("cnt_rst_again", {16'd0, rd_word_cnt}, 32'd0);
`endif

      check_eq("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
